// File: rtl/fdtd_step_sched_if.sv
// Chunk request handshake between the FDTD step scheduler and the mem_ctrl/acc datapath.
// The scheduler (master) holds sel/base/len stable while phase_req_o is high and waits for phase_done_i.
interface fdtd_step_sched_if #(
    parameter int CELL_W  = 15,
    parameter int CHUNK_W = 6
) ();
    logic               phase_req_o;
    logic [1:0]         phase_sel_o;
    logic [CELL_W-1:0]  chunk_base_o;
    logic [CHUNK_W-1:0] chunk_len_o;
    logic               phase_done_i;

    modport master (
        output phase_req_o,
        output phase_sel_o,
        output chunk_base_o,
        output chunk_len_o,
        input  phase_done_i
    );

    modport slave (
        input  phase_req_o,
        input  phase_sel_o,
        input  chunk_base_o,
        input  chunk_len_o,
        output phase_done_i
    );
endinterface

// File: rtl/fdtd_step_sched.sv
// FDTD time-step scheduler: walks the field in buffer-sized chunks for the Hy and Ez
// updates, injects the source once per step, and counts steps until the run completes.
// Every output comes straight from a register; the next-state logic computes all of them.
module fdtd_step_sched #(
    parameter int CELL_W  = 15,
    parameter int CHUNK_W = 6,
    parameter int STEP_W  = 16
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [CELL_W-1:0]   num_cells_i,
    input  logic [CHUNK_W-1:0]  chunk_size_i,
    input  logic [STEP_W-1:0]   num_steps_i,
    fdtd_step_sched_if.master   phase,
    output logic                busy_o,
    output logic [STEP_W-1:0]   step_cnt_o,
    output logic                done_o,
    output logic                err_o
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HY   = 3'd1,
        EZ   = 3'd2,
        SRC  = 3'd3,
        STEP = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [STEP_W-1:0]  STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [CHUNK_W-1:0] LEN_ONE   = {{(CHUNK_W-1){1'b0}}, 1'b1};
    localparam logic [CELL_W-1:0]  BASE_ZERO = {CELL_W{1'b0}};

    // Cells in the chunk starting at base: the chunk size, clipped at the end of the field.
    function automatic logic [CHUNK_W-1:0] chunk_len_f(
        input logic [CELL_W-1:0]  cells,
        input logic [CELL_W-1:0]  base,
        input logic [CHUNK_W-1:0] chunk
    );
        logic [CELL_W-1:0] remain;
        remain = cells - base;
        if (CELL_W'(chunk) <= remain) begin
            return chunk;
        end else begin
            return remain[CHUNK_W-1:0];
        end
    endfunction

    state_t             state_r, state_s;
    logic [CELL_W-1:0]  cells_r, cells_s;
    logic [CHUNK_W-1:0] chunk_r, chunk_s;
    logic [STEP_W-1:0]  steps_r, steps_s;
    logic [CELL_W-1:0]  base_r, base_s;
    logic [CHUNK_W-1:0] len_r, len_s;
    logic [1:0]         sel_r, sel_s;
    logic               req_r, req_s;
    logic [STEP_W-1:0]  step_cnt_r, step_cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_r, err_s;
    logic [CELL_W:0]    sum_s;
    logic               last_chunk_s;

    // One extra bit on the base sum so a chunk ending at the top of the cell range cannot wrap.
    always_comb begin
        sum_s        = {1'b0, base_r} + (CELL_W+1)'(len_r);
        last_chunk_s = (sum_s >= {1'b0, cells_r});
    end

    // Next-state and next-output logic; abort wins over a same-cycle chunk completion.
    always_comb begin
        state_s    = state_r;
        cells_s    = cells_r;
        chunk_s    = chunk_r;
        steps_s    = steps_r;
        base_s     = base_r;
        len_s      = len_r;
        sel_s      = sel_r;
        req_s      = req_r;
        step_cnt_s = step_cnt_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        err_s      = err_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if ((num_cells_i == BASE_ZERO) || (chunk_size_i == {CHUNK_W{1'b0}}) ||
                        (num_steps_i == {STEP_W{1'b0}})) begin
                        err_s = 1'b1;
                    end else begin
                        cells_s    = num_cells_i;
                        chunk_s    = chunk_size_i;
                        steps_s    = num_steps_i;
                        state_s    = HY;
                        base_s     = BASE_ZERO;
                        step_cnt_s = {STEP_W{1'b0}};
                        err_s      = 1'b0;
                        busy_s     = 1'b1;
                        req_s      = 1'b1;
                        sel_s      = 2'd0;
                        len_s      = chunk_len_f(num_cells_i, BASE_ZERO, chunk_size_i);
                    end
                end else begin
                    req_s = 1'b0;
                end
            end
            HY, EZ: begin
                if (abort_i) begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                    busy_s  = 1'b0;
                end else if (!req_r) begin
                    req_s = 1'b1;
                    sel_s = (state_r == HY) ? 2'd0 : 2'd1;
                    len_s = chunk_len_f(cells_r, base_r, chunk_r);
                end else if (phase.phase_done_i) begin
                    req_s = 1'b0;
                    if (last_chunk_s) begin
                        base_s  = BASE_ZERO;
                        state_s = (state_r == HY) ? EZ : SRC;
                    end else begin
                        base_s = sum_s[CELL_W-1:0];
                    end
                end else begin
                    req_s = 1'b1;
                end
            end
            SRC: begin
                if (abort_i) begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                    busy_s  = 1'b0;
                end else if (!req_r) begin
                    req_s  = 1'b1;
                    sel_s  = 2'd2;
                    base_s = BASE_ZERO;
                    len_s  = LEN_ONE;
                end else if (phase.phase_done_i) begin
                    req_s   = 1'b0;
                    state_s = STEP;
                end else begin
                    req_s = 1'b1;
                end
            end
            STEP: begin
                if (abort_i) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end else begin
                    step_cnt_s = step_cnt_r + STEP_ONE;
                    if ((step_cnt_r + STEP_ONE) == steps_r) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = HY;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by ARESETn.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r    <= IDLE;
            cells_r    <= BASE_ZERO;
            chunk_r    <= {CHUNK_W{1'b0}};
            steps_r    <= {STEP_W{1'b0}};
            base_r     <= BASE_ZERO;
            len_r      <= {CHUNK_W{1'b0}};
            sel_r      <= 2'd0;
            req_r      <= 1'b0;
            step_cnt_r <= {STEP_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cells_r    <= cells_s;
            chunk_r    <= chunk_s;
            steps_r    <= steps_s;
            base_r     <= base_s;
            len_r      <= len_s;
            sel_r      <= sel_s;
            req_r      <= req_s;
            step_cnt_r <= step_cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    assign phase.phase_req_o  = req_r;
    assign phase.phase_sel_o  = sel_r;
    assign phase.chunk_base_o = base_r;
    assign phase.chunk_len_o  = len_r;
    assign busy_o             = busy_r;
    assign step_cnt_o         = step_cnt_r;
    assign done_o             = done_r;
    assign err_o              = err_r;
endmodule

// File: tb/tb_fdtd_step_sched.sv
// Directed bench for fdtd_step_sched: drives inputs and samples outputs on the falling edge.
module tb_fdtd_step_sched;
    localparam int CELL_W  = 15;
    localparam int CHUNK_W = 6;
    localparam int STEP_W  = 16;

    logic               ACLK         = 1'b0;
    logic               ARESETn      = 1'b0;
    logic               start_i      = 1'b0;
    logic               abort_i      = 1'b0;
    logic [CELL_W-1:0]  num_cells_i  = '0;
    logic [CHUNK_W-1:0] chunk_size_i = '0;
    logic [STEP_W-1:0]  num_steps_i  = '0;
    logic               busy_o;
    logic [STEP_W-1:0]  step_cnt_o;
    logic               done_o;
    logic               err_o;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int d0;

    fdtd_step_sched_if #(.CELL_W(CELL_W), .CHUNK_W(CHUNK_W)) phase_if ();

    fdtd_step_sched #(.CELL_W(CELL_W), .CHUNK_W(CHUNK_W), .STEP_W(STEP_W)) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .num_cells_i  (num_cells_i),
        .chunk_size_i (chunk_size_i),
        .num_steps_i  (num_steps_i),
        .phase        (phase_if),
        .busy_o       (busy_o),
        .step_cnt_o   (step_cnt_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 ACLK = ~ACLK;

    // Count done pulses seen by the datapath side.
    always @(negedge ACLK) begin
        if (done_o === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int cells, input int chunk, input int steps);
        num_cells_i  = CELL_W'(cells);
        chunk_size_i = CHUNK_W'(chunk);
        num_steps_i  = STEP_W'(steps);
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
    endtask

    // Wait for a request, check its fields, answer it three cycles later, check the gap cycle.
    task automatic do_chunk(input string tag, input int sel, input int base, input int len,
                            input bit noise);
        int n;
        n = 0;
        while (phase_if.phase_req_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("%s req", tag), {31'd0, phase_if.phase_req_o}, 32'd1);
        check($sformatf("%s sel", tag), {30'd0, phase_if.phase_sel_o}, sel);
        check($sformatf("%s base", tag), {17'd0, phase_if.chunk_base_o}, base);
        check($sformatf("%s len", tag), {26'd0, phase_if.chunk_len_o}, len);
        if (noise) begin
            start_i     = 1'b1;
            num_cells_i = 15'd7;
            chunk_size_i = 6'd3;
        end
        tick();
        start_i = 1'b0;
        tick();
        check($sformatf("%s hold", tag), {17'd0, phase_if.chunk_base_o}, base);
        phase_if.phase_done_i = 1'b1;
        tick();
        phase_if.phase_done_i = 1'b0;
        check($sformatf("%s gap", tag), {31'd0, phase_if.phase_req_o}, 32'd0);
        if (noise) begin
            phase_if.phase_done_i = 1'b1;
            tick();
            phase_if.phase_done_i = 1'b0;
        end
    endtask

    task automatic wait_done(input int steps);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("done pulse", {31'd0, done_o}, 32'd1);
        check("done step_cnt", {16'd0, step_cnt_o}, steps);
        tick();
        check("done width", {31'd0, done_o}, 32'd0);
        check("idle busy", {31'd0, busy_o}, 32'd0);
        tick();
        check("step_cnt hold", {16'd0, step_cnt_o}, steps);
    endtask

    task automatic run_120(input bit noise);
        d0 = done_cnt;
        start_run(120, 50, 1);
        check("start busy", {31'd0, busy_o}, 32'd1);
        do_chunk("hy0", 0, 0, 50, noise);
        do_chunk("hy1", 0, 50, 50, noise);
        do_chunk("hy2", 0, 100, 20, noise);
        do_chunk("ez0", 1, 0, 50, noise);
        do_chunk("ez1", 1, 50, 50, noise);
        do_chunk("ez2", 1, 100, 20, noise);
        do_chunk("src", 2, 0, 1, noise);
        wait_done(1);
        check("done count", done_cnt - d0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s req", tag), {31'd0, phase_if.phase_req_o}, 32'd0);
        check($sformatf("%s sel", tag), {30'd0, phase_if.phase_sel_o}, 32'd0);
        check($sformatf("%s base", tag), {17'd0, phase_if.chunk_base_o}, 32'd0);
        check($sformatf("%s len", tag), {26'd0, phase_if.chunk_len_o}, 32'd0);
        check($sformatf("%s busy", tag), {31'd0, busy_o}, 32'd0);
        check($sformatf("%s step_cnt", tag), {16'd0, step_cnt_o}, 32'd0);
        check($sformatf("%s done", tag), {31'd0, done_o}, 32'd0);
        check($sformatf("%s err", tag), {31'd0, err_o}, 32'd0);
    endtask

    initial begin
        phase_if.phase_done_i = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        ARESETn = 1'b1;
        tick();

        // Three-chunk field, one step.
        run_120(1'b0);

        // Same run with a stray start, stray done and input changes during the run.
        run_120(1'b1);

        // Single-chunk field, three steps.
        d0 = done_cnt;
        start_run(50, 50, 3);
        for (int s = 0; s < 3; s++) begin
            do_chunk("s3 hy", 0, 0, 50, 1'b0);
            do_chunk("s3 ez", 1, 0, 50, 1'b0);
            do_chunk("s3 src", 2, 0, 1, 1'b0);
            if (s < 2) check("s3 no early done", done_cnt - d0, 32'd0);
        end
        wait_done(3);
        check("s3 done count", done_cnt - d0, 32'd1);

        // Zero chunk size is rejected; a later valid start clears the error.
        start_run(50, 0, 1);
        check("err set", {31'd0, err_o}, 32'd1);
        check("err busy", {31'd0, busy_o}, 32'd0);
        tick();
        tick();
        check("err no req", {31'd0, phase_if.phase_req_o}, 32'd0);
        check("err step_cnt kept", {16'd0, step_cnt_o}, 32'd3);
        start_run(40, 50, 1);
        check("err cleared", {31'd0, err_o}, 32'd0);
        check("restart busy", {31'd0, busy_o}, 32'd1);
        do_chunk("big hy", 0, 0, 40, 1'b0);
        do_chunk("big ez", 1, 0, 40, 1'b0);
        do_chunk("big src", 2, 0, 1, 1'b0);
        wait_done(1);

        // Abort during the second Hy chunk together with its done.
        d0 = done_cnt;
        start_run(120, 50, 2);
        do_chunk("ab hy0", 0, 0, 50, 1'b0);
        tick();
        check("ab hy1 req", {31'd0, phase_if.phase_req_o}, 32'd1);
        check("ab hy1 base", {17'd0, phase_if.chunk_base_o}, 32'd50);
        abort_i               = 1'b1;
        phase_if.phase_done_i = 1'b1;
        tick();
        abort_i               = 1'b0;
        phase_if.phase_done_i = 1'b0;
        check("ab req", {31'd0, phase_if.phase_req_o}, 32'd0);
        check("ab busy", {31'd0, busy_o}, 32'd0);
        check("ab step_cnt", {16'd0, step_cnt_o}, 32'd0);
        repeat (4) tick();
        check("ab stays idle", {31'd0, phase_if.phase_req_o}, 32'd0);
        check("ab no done", done_cnt - d0, 32'd0);

        // Asynchronous reset in the Ez phase of the second step.
        start_run(50, 50, 2);
        do_chunk("rs hy0", 0, 0, 50, 1'b0);
        do_chunk("rs ez0", 1, 0, 50, 1'b0);
        do_chunk("rs src0", 2, 0, 1, 1'b0);
        do_chunk("rs hy1", 0, 0, 50, 1'b0);
        tick();
        check("rs ez1 req", {31'd0, phase_if.phase_req_o}, 32'd1);
        check("rs ez1 sel", {30'd0, phase_if.phase_sel_o}, 32'd1);
        check("rs ez1 step_cnt", {16'd0, step_cnt_o}, 32'd1);
        ARESETn = 1'b0;
        #1;
        check_reset_outputs("midrun");
        tick();
        ARESETn = 1'b1;
        repeat (5) tick();
        check("rs no req", {31'd0, phase_if.phase_req_o}, 32'd0);
        check("rs no busy", {31'd0, busy_o}, 32'd0);
        start_run(50, 50, 1);
        check("rs restart busy", {31'd0, busy_o}, 32'd1);
        do_chunk("rs2 hy", 0, 0, 50, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
